// File: rtl/core_pkg.sv
// core_pkg: shared writeback types, widths and the operand forwarding helper.
package core_pkg;
    localparam int XLEN = 32;
    localparam int STARVE_LIMIT = 4;

    typedef logic [4:0] reg_addr_t;

    typedef struct packed {
        logic            valid;
        reg_addr_t       rd;
        logic [XLEN-1:0] data;
    } wb_entry_t;

    // {valid, data}; youngest result first: LSU slot, ALU slot, then output stage
    function automatic logic [XLEN:0] fwd(reg_addr_t a, wb_entry_t lsu_e, wb_entry_t alu_e, wb_entry_t out_e);
        return (a == '0) ? '0 :
               (lsu_e.valid && lsu_e.rd == a) ? {1'b1, lsu_e.data} :
               (alu_e.valid && alu_e.rd == a) ? {1'b1, alu_e.data} :
               (out_e.valid && out_e.rd == a) ? {1'b1, out_e.data} : '0;
    endfunction
endpackage

// File: rtl/wb_slot.sv
// wb_slot: single-entry result holding register; refills in the cycle it is granted.
module wb_slot
    import core_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            valid_i,
    output logic            ready_o,
    input  reg_addr_t       rd_i,
    input  logic [XLEN-1:0] data_i,
    input  logic            grant_i,
    output wb_entry_t       entry_o
);
    assign ready_o = !entry_o.valid || grant_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) entry_o <= '0;
        else if (valid_i && ready_o) entry_o <= '{valid: 1'b1, rd: rd_i, data: data_i};
        else if (grant_i) entry_o.valid <= 1'b0;
    end
endmodule

// File: rtl/writeback_unit.sv
// writeback_unit: arbitrates ALU/LSU results onto the regfile write port,
// tracks in-flight destinations and forwards uncommitted results.
module writeback_unit
    import core_pkg::*;
#(
    parameter int XLEN         = core_pkg::XLEN,
    parameter int STARVE_LIMIT = core_pkg::STARVE_LIMIT
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            alu_valid_i,
    output logic            alu_ready_o,
    input  reg_addr_t       alu_rd_i,
    input  logic [XLEN-1:0] alu_data_i,
    input  logic            lsu_valid_i,
    output logic            lsu_ready_o,
    input  reg_addr_t       lsu_rd_i,
    input  logic [XLEN-1:0] lsu_data_i,
    input  logic            issue_valid_i,
    input  reg_addr_t       issue_rd_i,
    output logic [31:0]     pending_o,
    input  reg_addr_t       rs1_addr_i,
    input  reg_addr_t       rs2_addr_i,
    output logic            rs1_fwd_valid_o,
    output logic [XLEN-1:0] rs1_fwd_data_o,
    output logic            rs2_fwd_valid_o,
    output logic [XLEN-1:0] rs2_fwd_data_o,
    output logic            reg_wr_en_o,
    output reg_addr_t       rd_addr_o,
    output logic [XLEN-1:0] wr_data_o
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIM = SW'(STARVE_LIMIT);

    wb_entry_t     alu_q, lsu_q, out_q, sel;
    logic          alu_gnt, lsu_gnt;
    logic [SW-1:0] starve_q;
    logic [31:0]   pending_q, set_v, clr_v;

    wb_slot u_alu (
        .clk_i, .rst_ni, .valid_i(alu_valid_i), .ready_o(alu_ready_o),
        .rd_i(alu_rd_i), .data_i(alu_data_i), .grant_i(alu_gnt), .entry_o(alu_q)
    );

    wb_slot u_lsu (
        .clk_i, .rst_ni, .valid_i(lsu_valid_i), .ready_o(lsu_ready_o),
        .rd_i(lsu_rd_i), .data_i(lsu_data_i), .grant_i(lsu_gnt), .entry_o(lsu_q)
    );

    always_comb begin
        alu_gnt = alu_q.valid && (!lsu_q.valid || starve_q == LIM);
        lsu_gnt = lsu_q.valid && !alu_gnt;
        sel     = alu_gnt ? alu_q : lsu_q;
        set_v   = (issue_valid_i && issue_rd_i != '0) ? 32'd1 << issue_rd_i : '0;
        clr_v   = out_q.valid ? 32'd1 << out_q.rd : '0;
    end

    // rd=0 results are consumed but never reach the write port
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            starve_q  <= '0;
            out_q     <= '0;
            pending_q <= '0;
        end else begin
            starve_q  <= alu_gnt ? '0 : (alu_q.valid && starve_q != LIM) ? starve_q + 1'b1 : starve_q;
            out_q     <= ((alu_gnt || lsu_gnt) && sel.rd != '0) ? sel : '0;
            pending_q <= (pending_q & ~clr_v) | set_v;
        end
    end

    assign {rs1_fwd_valid_o, rs1_fwd_data_o} = fwd(rs1_addr_i, lsu_q, alu_q, out_q);
    assign {rs2_fwd_valid_o, rs2_fwd_data_o} = fwd(rs2_addr_i, lsu_q, alu_q, out_q);
    assign reg_wr_en_o = out_q.valid;
    assign rd_addr_o   = out_q.rd;
    assign wr_data_o   = out_q.data;
    assign pending_o   = pending_q;

    // a re-issue is only legal in the same cycle the old write commits
    issue_to_pending: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (pending_q & ~clr_v & set_v) == '0);
endmodule

// File: tb/tb_writeback_unit.sv
// tb_writeback_unit: directed checks of arbitration, latency, scoreboard, forwarding and reset.
module tb_writeback_unit;
    import core_pkg::*;

    logic            clk_i, rst_ni;
    logic            alu_valid_i, alu_ready_o, lsu_valid_i, lsu_ready_o, issue_valid_i;
    reg_addr_t       alu_rd_i, lsu_rd_i, issue_rd_i, rs1_addr_i, rs2_addr_i, rd_addr_o;
    logic [XLEN-1:0] alu_data_i, lsu_data_i, rs1_fwd_data_o, rs2_fwd_data_o, wr_data_o;
    logic [31:0]     pending_o;
    logic            rs1_fwd_valid_o, rs2_fwd_valid_o, reg_wr_en_o;

    int checks = 0;
    int failures = 0;
    int ai, li, wn;
    logic ta, tl;
    logic [36:0] exp_w [12];

    writeback_unit dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .alu_valid_i(alu_valid_i), .alu_ready_o(alu_ready_o), .alu_rd_i(alu_rd_i), .alu_data_i(alu_data_i),
        .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o), .lsu_rd_i(lsu_rd_i), .lsu_data_i(lsu_data_i),
        .issue_valid_i(issue_valid_i), .issue_rd_i(issue_rd_i), .pending_o(pending_o),
        .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
        .rs1_fwd_valid_o(rs1_fwd_valid_o), .rs1_fwd_data_o(rs1_fwd_data_o),
        .rs2_fwd_valid_o(rs2_fwd_valid_o), .rs2_fwd_data_o(rs2_fwd_data_o),
        .reg_wr_en_o(reg_wr_en_o), .rd_addr_o(rd_addr_o), .wr_data_o(wr_data_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        exp_w = '{{5'd4, 32'hB000_0000}, {5'd4, 32'hB000_0001}, {5'd4, 32'hB000_0002}, {5'd4, 32'hB000_0003},
                  {5'd3, 32'hA000_0000}, {5'd4, 32'hB000_0004}, {5'd4, 32'hB000_0005}, {5'd4, 32'hB000_0006},
                  {5'd4, 32'hB000_0007}, {5'd3, 32'hA000_0001}, {5'd4, 32'hB000_0008}, {5'd3, 32'hA000_0002}};
        rst_ni = 1'b0;
        alu_valid_i = 1'b0; alu_rd_i = '0; alu_data_i = '0;
        lsu_valid_i = 1'b0; lsu_rd_i = '0; lsu_data_i = '0;
        issue_valid_i = 1'b0; issue_rd_i = '0; rs1_addr_i = '0; rs2_addr_i = '0;
        repeat (2) tick();
        chk("rst_wr_en", reg_wr_en_o, 0);
        chk("rst_rd_addr", rd_addr_o, 0);
        chk("rst_wr_data", wr_data_o, 0);
        chk("rst_pending", pending_o, 0);
        chk("rst_alu_ready", alu_ready_o, 1);
        chk("rst_lsu_ready", lsu_ready_o, 1);
        rst_ni = 1'b1;
        tick();

        alu_valid_i = 1'b1; alu_rd_i = 5'd5; alu_data_i = 32'hDEAD_BEEF;
        #1;
        chk("single_ready", alu_ready_o, 1);
        tick();
        alu_valid_i = 1'b0;
        chk("single_n1_wr_en", reg_wr_en_o, 0);
        tick();
        chk("single_wr_en", reg_wr_en_o, 1);
        chk("single_rd", rd_addr_o, 5);
        chk("single_data", wr_data_o, 32'hDEAD_BEEF);
        tick();
        chk("single_one_wide", reg_wr_en_o, 0);

        lsu_valid_i = 1'b1; lsu_rd_i = 5'd9; lsu_data_i = 32'h1234;
        tick();
        lsu_data_i = 32'h5678; rs1_addr_i = 5'd9;
        #1;
        chk("fwd_lsu_valid", rs1_fwd_valid_o, 1);
        chk("fwd_lsu_data", rs1_fwd_data_o, 32'h1234);
        tick();
        lsu_valid_i = 1'b0;
        #1;
        chk("fwd_slot_over_out", rs1_fwd_data_o, 32'h5678);
        chk("fwd_out_wr_data", wr_data_o, 32'h1234);
        tick();
        chk("fwd_second_write", wr_data_o, 32'h5678);
        chk("fwd_out_stage", rs1_fwd_data_o, 32'h5678);
        tick();
        chk("fwd_none_valid", rs1_fwd_valid_o, 0);
        chk("fwd_none_data", rs1_fwd_data_o, 0);
        rs1_addr_i = '0;

        issue_valid_i = 1'b1; issue_rd_i = 5'd7;
        tick();
        issue_valid_i = 1'b0;
        chk("sb_set", pending_o, 32'h80);
        alu_valid_i = 1'b1; alu_rd_i = 5'd7; alu_data_i = 32'h77;
        tick();
        alu_valid_i = 1'b0; rs1_addr_i = 5'd7;
        #1;
        chk("sb_hold_slot", pending_o, 32'h80);
        chk("fwd_alu_valid", rs1_fwd_valid_o, 1);
        chk("fwd_alu_data", rs1_fwd_data_o, 32'h77);
        tick();
        chk("sb_commit_en", reg_wr_en_o, 1);
        chk("sb_commit_rd", rd_addr_o, 7);
        chk("sb_hold_out", pending_o, 32'h80);
        issue_valid_i = 1'b1; issue_rd_i = 5'd7; rs1_addr_i = '0; rs2_addr_i = 5'd7;
        #1;
        chk("fwd_rs2_valid", rs2_fwd_valid_o, 1);
        chk("fwd_rs2_data", rs2_fwd_data_o, 32'h77);
        tick();
        issue_valid_i = 1'b0; rs2_addr_i = '0;
        chk("sb_set_wins", pending_o, 32'h80);
        chk("sb_idle_en", reg_wr_en_o, 0);
        alu_valid_i = 1'b1; alu_data_i = 32'h78;
        tick();
        alu_valid_i = 1'b0;
        tick();
        chk("sb_commit2_en", reg_wr_en_o, 1);
        chk("sb_before_clear", pending_o, 32'h80);
        tick();
        chk("sb_cleared", pending_o, 0);

        alu_valid_i = 1'b1; alu_rd_i = '0; alu_data_i = 32'hFFFF_FFFF;
        #1;
        chk("rd0_ready", alu_ready_o, 1);
        tick();
        alu_valid_i = 1'b0;
        #1;
        chk("rd0_no_fwd", rs1_fwd_valid_o, 0);
        repeat (3) begin
            tick();
            chk("rd0_no_write", reg_wr_en_o, 0);
            chk("rd0_pending", pending_o, 0);
        end

        ai = 0; li = 0; wn = 0;
        alu_rd_i = 5'd3; lsu_rd_i = 5'd4;
        for (int c = 0; c < 20; c++) begin
            alu_valid_i = (wn < 10); lsu_valid_i = (wn < 10);
            alu_data_i = 32'hA000_0000 + 32'(ai);
            lsu_data_i = 32'hB000_0000 + 32'(li);
            #1;
            ta = alu_valid_i && alu_ready_o;
            tl = lsu_valid_i && lsu_ready_o;
            tick();
            if (ta) ai++;
            if (tl) li++;
            if (reg_wr_en_o) begin
                if (wn < 12) chk("starve_write", {rd_addr_o, wr_data_o}, exp_w[wn]);
                wn++;
            end
        end
        chk("starve_total_writes", wn, 12);
        chk("starve_alu_accepted", ai, 3);
        chk("starve_lsu_accepted", li, 9);

        alu_valid_i = 1'b1; alu_rd_i = 5'd11; alu_data_i = 32'h1;
        lsu_valid_i = 1'b1; lsu_rd_i = 5'd12; lsu_data_i = 32'h2;
        issue_valid_i = 1'b1; issue_rd_i = 5'd13;
        tick();
        issue_valid_i = 1'b0; lsu_rd_i = 5'd14; lsu_data_i = 32'h3;
        chk("mid_pending", pending_o, 32'h2000);
        tick();
        chk("mid_write_en", reg_wr_en_o, 1);
        chk("mid_write_rd", rd_addr_o, 12);
        chk("mid_alu_blocked", alu_ready_o, 0);
        alu_valid_i = 1'b0; lsu_valid_i = 1'b0; rs1_addr_i = 5'd11;
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_en", reg_wr_en_o, 0);
        chk("mid_rst_rd", rd_addr_o, 0);
        chk("mid_rst_data", wr_data_o, 0);
        chk("mid_rst_pending", pending_o, 0);
        chk("mid_rst_fwd", rs1_fwd_valid_o, 0);
        rs1_addr_i = '0;
        repeat (2) tick();
        rst_ni = 1'b1;
        repeat (4) begin
            tick();
            chk("post_rst_no_write", reg_wr_en_o, 0);
        end
        chk("post_rst_alu_ready", alu_ready_o, 1);
        chk("post_rst_lsu_ready", lsu_ready_o, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
